// File: rtl/chan_mux_pkg.sv
// Shared constants and helpers for the chan_mux_rr channel selector.
package chan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Index width for n channels; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chan_mux_rr_arbiter.sv
// Rotating-priority arbiter: purely combinational. The pointer that sets the
// highest-priority channel is kept by the caller.
module rr_arbiter
  import chan_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic             gnt_vld,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [SEL_W:0] cand;

  // Scan ptr, ptr+1, ... wrapping modulo N_CH; first requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = {1'b0, ptr} + (SEL_W+1)'(i);
      if (cand >= (SEL_W+1)'(N_CH)) cand = cand - (SEL_W+1)'(N_CH);
      if (en && !gnt_vld && req[cand[SEL_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel data selector with a registered output slot and valid/ready on
// both sides. MANUAL mode follows sel; RR mode arbitrates round-robin.
// Optional build macro CHAN_MUX_SEL_ERR_EN: flags an out-of-range sel in
// MANUAL mode with a sticky err bit. Without it err is tied low.
module chan_mux_rr
  import chan_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  localparam int SEL_W = clog2_min1(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready,
  output logic                  err
);

  localparam int SEL_SPAN = 1 << SEL_W;

  logic                vld_p1;
  logic [WIDTH-1:0]    data_p1;
  logic [SEL_W-1:0]    ch_p1;
  logic [SEL_W-1:0]    ptr;
  logic                live;

  logic                free;
  logic                is_rr;
  logic                sel_ok;
  logic [SEL_SPAN-1:0] valid_ext;
  logic                man_vld;
  logic                rr_vld;
  logic [SEL_W-1:0]    rr_idx;
  logic                grant;
  logic [SEL_W-1:0]    g_idx;
  logic [WIDTH-1:0]    g_data;
  logic [SEL_W-1:0]    ptr_nxt;

  // live keeps in_ready low while reset is asserted and for the release cycle.
  assign free      = ~vld_p1 | out_ready;
  assign is_rr     = (mode == MODE_RR);
  assign sel_ok    = ({1'b0, sel} < (SEL_W+1)'(N_CH));
  assign valid_ext = SEL_SPAN'(in_valid);
  assign man_vld   = sel_ok & valid_ext[sel];

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .en      (free & is_rr),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  // Grant selection between the two modes, handshake and data mux.
  always_comb begin
    grant  = live & free & (is_rr ? rr_vld : man_vld);
    g_idx  = is_rr ? rr_idx : sel;
    in_ready = '0;
    if (grant) in_ready[g_idx] = 1'b1;
    g_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (g_idx == SEL_W'(k)) g_data = in_data[k*WIDTH +: WIDTH];
    end
    ptr_nxt = (g_idx == SEL_W'(N_CH-1)) ? '0 : g_idx + 1'b1;
  end

  // p0 -> p1: output slot loads on grant, empties when drained with no grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live    <= 1'b0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      ptr     <= '0;
    end else begin
      live <= 1'b1;
      if (free) begin
        vld_p1 <= grant;
        if (grant) begin
          data_p1 <= g_data;
          ch_p1   <= g_idx;
        end
      end
      if (grant && is_rr) ptr <= ptr_nxt;
    end
  end

`ifdef CHAN_MUX_SEL_ERR_EN
  logic err_q;

  // Sticky flag: an arbitration attempt in MANUAL mode with sel past the last channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (live && free && !is_rr && !sel_ok) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_ch    = ch_p1;

endmodule

// File: tb/tb_chan_mux_rr.sv
// Directed bench for chan_mux_rr: a 4-channel instance driven from a vector
// table, plus a 3-channel instance for the out-of-range select case.
module tb_chan_mux_rr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-channel, 8-bit instance
  logic        mode, out_ready, out_valid, err;
  logic [1:0]  sel, out_ch;
  logic [3:0]  in_valid, in_ready;
  logic [31:0] in_data;
  logic [7:0]  out_data;

  // 3-channel, 8-bit instance
  logic        mode3, out_ready3, out_valid3, err3;
  logic [1:0]  sel3, out_ch3;
  logic [2:0]  in_valid3, in_ready3;
  logic [23:0] in_data3;
  logic [7:0]  out_data3;

  chan_mux_rr #(.N_CH(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready), .err(err)
  );

  chan_mux_rr #(.N_CH(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
    .out_ready(out_ready3), .err(err3)
  );

`ifdef CHAN_MUX_SEL_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] ir;
    logic       ov;
    logic [7:0] od;
    logic [1:0] oc;
  } vec_t;

  localparam logic M = 1'b0;
  localparam logic R = 1'b1;

  vec_t tbl[25];
  int   nvec = 0;
  int   nmis = 0;

  function automatic vec_t mk(logic md, logic [1:0] s, logic [3:0] iv, logic rdy,
                              logic [3:0] ir, logic ov, logic [7:0] od, logic [1:0] oc);
    vec_t v;
    v.mode = md; v.sel = s; v.iv = iv; v.ordy = rdy;
    v.ir = ir; v.ov = ov; v.od = od; v.oc = oc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge: drive, check handshake, clock, check slot.
  task automatic apply(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    mode = v.mode; sel = v.sel; in_valid = v.iv; out_ready = v.ordy;
    #2;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(v.ir));
    @(posedge clk); #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v.ov));
    chk({tag, ".out_data"},  32'(out_data),  32'(v.od));
    chk({tag, ".out_ch"},    32'(out_ch),    32'(v.oc));
    chk({tag, ".err"},       32'(err),       32'(0));
    nvec++;
  endtask

  initial begin
    // channel data: ch3=0F ch2=0B ch1=05 ch0=0A
    in_data  = {8'h0F, 8'h0B, 8'h05, 8'h0A};
    in_data3 = {8'h33, 8'h22, 8'h11};
    mode = M; sel = 2'd0; in_valid = 4'h0; out_ready = 1'b1;
    mode3 = M; sel3 = 2'd0; in_valid3 = 3'b000; out_ready3 = 1'b1;

    // manual stepping sel 0..3
    tbl[0]  = mk(M, 2'd0, 4'hF, 1, 4'b0001, 1, 8'h0A, 2'd0);
    tbl[1]  = mk(M, 2'd1, 4'hF, 1, 4'b0010, 1, 8'h05, 2'd1);
    tbl[2]  = mk(M, 2'd2, 4'hF, 1, 4'b0100, 1, 8'h0B, 2'd2);
    tbl[3]  = mk(M, 2'd3, 4'hF, 1, 4'b1000, 1, 8'h0F, 2'd3);
    // round-robin, all valid, no bubbles
    tbl[4]  = mk(R, 2'd0, 4'hF, 1, 4'b0001, 1, 8'h0A, 2'd0);
    tbl[5]  = mk(R, 2'd0, 4'hF, 1, 4'b0010, 1, 8'h05, 2'd1);
    tbl[6]  = mk(R, 2'd0, 4'hF, 1, 4'b0100, 1, 8'h0B, 2'd2);
    tbl[7]  = mk(R, 2'd0, 4'hF, 1, 4'b1000, 1, 8'h0F, 2'd3);
    tbl[8]  = mk(R, 2'd0, 4'hF, 1, 4'b0001, 1, 8'h0A, 2'd0);
    // channel 1 drops out: 2,3,0
    tbl[9]  = mk(R, 2'd0, 4'hD, 1, 4'b0100, 1, 8'h0B, 2'd2);
    tbl[10] = mk(R, 2'd0, 4'hD, 1, 4'b1000, 1, 8'h0F, 2'd3);
    tbl[11] = mk(R, 2'd0, 4'hD, 1, 4'b0001, 1, 8'h0A, 2'd0);
    // 3-cycle stall, then next in RR order (ptr=1 -> ch2)
    tbl[12] = mk(R, 2'd0, 4'hD, 0, 4'b0000, 1, 8'h0A, 2'd0);
    tbl[13] = mk(R, 2'd0, 4'hD, 0, 4'b0000, 1, 8'h0A, 2'd0);
    tbl[14] = mk(R, 2'd0, 4'hD, 0, 4'b0000, 1, 8'h0A, 2'd0);
    tbl[15] = mk(R, 2'd0, 4'hD, 1, 4'b0100, 1, 8'h0B, 2'd2);
    // switch to MANUAL sel=1 while stalled, then release
    tbl[16] = mk(M, 2'd1, 4'hF, 0, 4'b0000, 1, 8'h0B, 2'd2);
    tbl[17] = mk(M, 2'd1, 4'hF, 0, 4'b0000, 1, 8'h0B, 2'd2);
    tbl[18] = mk(M, 2'd1, 4'hF, 1, 4'b0010, 1, 8'h05, 2'd1);
    // back to RR: ptr still 3 after manual grants
    tbl[19] = mk(R, 2'd0, 4'hF, 1, 4'b1000, 1, 8'h0F, 2'd3);
    // nothing to grant: slot empties, data/ch hold
    tbl[20] = mk(R, 2'd0, 4'h0, 1, 4'b0000, 0, 8'h0F, 2'd3);
    tbl[21] = mk(M, 2'd2, 4'hB, 1, 4'b0000, 0, 8'h0F, 2'd3);
    // empty slot is free even with out_ready low
    tbl[22] = mk(M, 2'd2, 4'h4, 0, 4'b0100, 1, 8'h0B, 2'd2);
    // drain, RR from ptr=0 -> ch0, ptr becomes 1
    tbl[23] = mk(R, 2'd0, 4'hF, 1, 4'b0001, 1, 8'h0A, 2'd0);
    // the post-reset vector: ptr must be back at 0
    tbl[24] = mk(R, 2'd0, 4'hF, 1, 4'b0001, 1, 8'h0A, 2'd0);

    // power-on reset, release away from the edge
    repeat (2) @(posedge clk);
    #2;
    chk("por.out_valid", 32'(out_valid), 32'(0));
    chk("por.in_ready",  32'(in_ready),  32'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 24; i++) apply(tbl[i], i);

    // asynchronous reset mid-stream: slot clears without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'(0));
    chk("rst.out_data",  32'(out_data),  32'(0));
    chk("rst.out_ch",    32'(out_ch),    32'(0));
    chk("rst.err",       32'(err),       32'(0));
    chk("rst.in_ready",  32'(in_ready),  32'(0));
    nvec++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    apply(tbl[24], 24);

    // 3-channel instance: out-of-range sel in MANUAL mode
    mode3 = M; sel3 = 2'd0; in_valid3 = 3'b111; out_ready3 = 1'b1;
    #2 chk("n3.sel0.in_ready", 32'(in_ready3), 32'(3'b001));
    @(posedge clk); #1;
    chk("n3.sel0.out_valid", 32'(out_valid3), 32'(1));
    chk("n3.sel0.out_data",  32'(out_data3),  32'(8'h11));
    chk("n3.sel0.err",       32'(err3),       32'(0));
    nvec++;

    sel3 = 2'd3;
    #2 chk("n3.sel3.in_ready", 32'(in_ready3), 32'(0));
    @(posedge clk); #1;
    chk("n3.sel3.out_valid", 32'(out_valid3), 32'(0));
    chk("n3.sel3.out_data",  32'(out_data3),  32'(8'h11));
    chk("n3.sel3.err",       32'(err3),       32'(EXP_ERR));
    nvec++;

    sel3 = 2'd2;
    #2 chk("n3.sel2.in_ready", 32'(in_ready3), 32'(3'b100));
    @(posedge clk); #1;
    chk("n3.sel2.out_valid", 32'(out_valid3), 32'(1));
    chk("n3.sel2.out_data",  32'(out_data3),  32'(8'h33));
    chk("n3.sel2.out_ch",    32'(out_ch3),    32'(2));
    chk("n3.sel2.err",       32'(err3),       32'(EXP_ERR));
    nvec++;

    // RR ignores sel; ptr is still 0 after manual grants
    mode3 = R; sel3 = 2'd3;
    #2 chk("n3.rr.in_ready", 32'(in_ready3), 32'(3'b001));
    @(posedge clk); #1;
    chk("n3.rr.out_data", 32'(out_data3), 32'(8'h11));
    chk("n3.rr.out_ch",   32'(out_ch3),   32'(0));
    chk("n3.rr.err",      32'(err3),      32'(EXP_ERR));
    nvec++;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
